// File: rtl/adder_share_pkg.sv
// Shared types and default sizing for the shared-adder arbiter block.
package adder_share_pkg;

    localparam int DEF_N    = 4;
    localparam int DEF_W    = 64;
    localparam int DEF_CNTW = 32;

    // One requester's slot in req_data: a in the low half, b in the high half.
    typedef struct packed {
        logic [DEF_W-1:0] b;
        logic [DEF_W-1:0] a;
    } operand_pair_t;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester-side operand bus plus result stream of the shared adder.
interface adder_share_arb_if
    import adder_share_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(N),
    parameter int CNTW = DEF_CNTW
);

    logic [N*2*W-1:0] req_data;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic             rr_mode;
    logic [W-1:0]     dout;
    logic [IDW-1:0]   dout_id;
    logic             dout_tvalid;
    logic             dout_tready;
    logic [CNTW-1:0]  grant_cnt;

    modport master (
        output req_data, req_valid, rr_mode, dout_tready,
        input  req_ready, dout, dout_id, dout_tvalid, grant_cnt
    );

    modport slave (
        input  req_data, req_valid, rr_mode, dout_tready,
        output req_ready, dout, dout_id, dout_tvalid, grant_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin / fixed-priority winner select; the pointer lives in the parent.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           rr_mode,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] win_idx,
    output logic           any_grant
);

    logic [IDW-1:0] base_s;

    // Index base+k folded back into 0..N-1; base is always below N.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return s[IDW-1:0];
    endfunction

    // First requester at or after the search base wins; fixed mode searches from zero.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        base_s    = rr_mode ? ptr : '0;
        for (int k = 0; k < N; k++) begin
            if (!any_grant && req[wrap_idx(base_s, k)]) begin
                any_grant = 1'b1;
                win_idx   = wrap_idx(base_s, k);
            end else begin
                any_grant = any_grant;
            end
        end
        if (any_grant) begin
            grant[win_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// One registered W-bit adder shared by N valid/ready requesters, result on a
// backpressured stream tagged with the winner's index.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(N),
    parameter int CNTW = DEF_CNTW
) (
    input  logic              clk,
    input  logic              rst,
    adder_share_arb_if.slave  bus
);

    state_t          state_r;
    logic [W-1:0]    dout_r;
    logic [IDW-1:0]  dout_id_r;
    logic            tvalid_r;
    logic [CNTW-1:0] cnt_r;
    logic [IDW-1:0]  ptr_r;

    logic            out_free_s;
    logic [N-1:0]    arb_req_s;
    logic [N-1:0]    grant_s;
    logic [IDW-1:0]  win_s;
    logic            any_s;
    logic [2*W-1:0]  pair_s;
    logic [W-1:0]    sum_s;

    // The output slot can take a new result when empty or draining this cycle;
    // reset also blocks grants so nothing is accepted while it is held.
    assign out_free_s = (state_r == ST_EMPTY) || bus.dout_tready;
    assign arb_req_s  = bus.req_valid & {N{out_free_s & ~rst}};

    rr_arbiter #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req       (arb_req_s),
        .ptr       (ptr_r),
        .rr_mode   (bus.rr_mode),
        .grant     (grant_s),
        .win_idx   (win_s),
        .any_grant (any_s)
    );

    // Select the winner's operand pair; data never feeds back into the grant logic.
    always_comb begin
        pair_s = '0;
        for (int i = 0; i < N; i++) begin
            if (win_s == IDW'(i)) begin
                pair_s = bus.req_data[i*2*W +: 2*W];
            end else begin
                pair_s = pair_s;
            end
        end
    end

    assign sum_s = pair_s[W-1:0] + pair_s[2*W-1:W];

    // Output-register FSM, fairness pointer and grant counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_EMPTY;
            dout_r    <= '0;
            dout_id_r <= '0;
            tvalid_r  <= 1'b0;
            cnt_r     <= '0;
            ptr_r     <= '0;
        end else begin
            if (any_s) begin
                cnt_r <= cnt_r + CNTW'(1);
                if (win_s == IDW'(N-1)) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= win_s + IDW'(1);
                end
            end else begin
                cnt_r <= cnt_r;
                ptr_r <= ptr_r;
            end

            case (state_r)
                ST_EMPTY: begin
                    if (any_s) begin
                        state_r   <= ST_FULL;
                        dout_r    <= sum_s;
                        dout_id_r <= win_s;
                        tvalid_r  <= 1'b1;
                    end else begin
                        state_r   <= ST_EMPTY;
                        tvalid_r  <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (bus.dout_tready && any_s) begin
                        // Drain and refill in the same cycle: no bubble.
                        state_r   <= ST_FULL;
                        dout_r    <= sum_s;
                        dout_id_r <= win_s;
                        tvalid_r  <= 1'b1;
                    end else if (bus.dout_tready) begin
                        state_r   <= ST_EMPTY;
                        dout_r    <= '0;
                        dout_id_r <= '0;
                        tvalid_r  <= 1'b0;
                    end else begin
                        state_r   <= ST_FULL;
                        tvalid_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_EMPTY;
                    dout_r    <= '0;
                    dout_id_r <= '0;
                    tvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.dout        = dout_r;
    assign bus.dout_id     = dout_id_r;
    assign bus.dout_tvalid = tvalid_r;
    assign bus.grant_cnt   = cnt_r;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: vector table for arbitration plus
// hand sequences for stall, wrap, drain, async reset and counter wrap.
module tb_adder_share_arb;
    import adder_share_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    logic [31:0] exp_cnt;

    adder_share_arb_if #(.N(4), .W(64), .CNTW(32)) bus ();
    // Second instance with a 4-bit counter so the counter wrap is reachable.
    adder_share_arb_if #(.N(4), .W(64), .CNTW(4))  bus_n ();

    assign bus_n.req_data    = bus.req_data;
    assign bus_n.req_valid   = bus.req_valid;
    assign bus_n.rr_mode     = bus.rr_mode;
    assign bus_n.dout_tready = bus.dout_tready;

    adder_share_arb #(.N(4), .W(64), .CNTW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adder_share_arb #(.N(4), .W(64), .CNTW(4)) dut_n (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected the test to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic        rr;
        logic        tready;
        logic [3:0]  exp_ready;
        logic        exp_tvalid;
        logic [1:0]  exp_id;
        logic [63:0] exp_dout;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [3:0] v, input logic r, input logic t,
                                input logic [3:0] er, input logic ev, input logic [1:0] ei,
                                input logic [63:0] ed);
        vec_t x;
        x.valid = v; x.rr = r; x.tready = t;
        x.exp_ready = er; x.exp_tvalid = ev; x.exp_id = ei; x.exp_dout = ed;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int i, input logic [63:0] a, input logic [63:0] b);
        operand_pair_t p;
        p.a = a;
        p.b = b;
        bus.req_data[i*128 +: 128] = p;
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [1:0] ei,
                             input logic [63:0] ed);
        chk({tag, " tvalid"}, {63'd0, bus.dout_tvalid}, {63'd0, ev});
        chk({tag, " id"},     {62'd0, bus.dout_id},     {62'd0, ei});
        chk({tag, " dout"},   bus.dout,                 ed);
        chk({tag, " cnt"},    {32'd0, bus.grant_cnt},   {32'd0, exp_cnt});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 32'd0;

        // Grant rotation, fixed priority, mode switch, drain, stall from the table.
        tbl[0]  = mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 64'd100);
        tbl[1]  = mk(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 64'd101);
        tbl[2]  = mk(4'b1111, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 64'd102);
        tbl[3]  = mk(4'b1111, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 64'd103);
        tbl[4]  = mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 64'd100);
        tbl[5]  = mk(4'b1111, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 64'd101);
        tbl[6]  = mk(4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 64'd101);
        tbl[7]  = mk(4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 64'd101);
        tbl[8]  = mk(4'b1010, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd1, 64'd101);
        tbl[9]  = mk(4'b1000, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 64'd103);
        tbl[10] = mk(4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 64'd100);
        tbl[11] = mk(4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 64'd102);
        tbl[12] = mk(4'b0011, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 64'd100);
        tbl[13] = mk(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 64'd0);
        tbl[14] = mk(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 64'd0);
        tbl[15] = mk(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 64'd102);
        tbl[16] = mk(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 64'd102);
        tbl[17] = mk(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 64'd102);

        // Reset with random inputs.
        rst = 1'b1;
        repeat (3) begin
            for (int i = 0; i < 8; i++) begin
                set_pair(i / 2, {$urandom, $urandom}, {$urandom, $urandom});
            end
            bus.req_valid   = 4'($urandom);
            bus.rr_mode     = 1'($urandom);
            bus.dout_tready = 1'($urandom);
            tick();
        end
        check_out("reset", 1'b0, 2'd0, 64'd0);
        chk("reset ready", {60'd0, bus.req_ready}, 64'd0);
        chk("reset cnt_n", {60'd0, bus_n.grant_cnt}, 64'd0);

        // First transaction after release.
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) set_pair(i, 64'd0, 64'd0);
        rst = 1'b0;
        set_pair(0, 64'd5, 64'd7);
        bus.req_valid   = 4'b0001;
        bus.rr_mode     = 1'b1;
        bus.dout_tready = 1'b1;
        #1;
        chk("first ready", {60'd0, bus.req_ready}, {60'd0, 4'b0001});
        tick();
        exp_cnt = 32'd1;
        check_out("first", 1'b1, 2'd0, 64'd12);
        bus.req_valid = 4'b0000;
        tick();
        chk("first drain tvalid", {63'd0, bus.dout_tvalid}, 64'd0);

        // Fresh pointer for the rotation table.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 32'd0;
        for (int i = 0; i < 4; i++) set_pair(i, 64'(i), 64'd100);

        for (int r = 0; r < 18; r++) begin
            bus.req_valid   = tbl[r].valid;
            bus.rr_mode     = tbl[r].rr;
            bus.dout_tready = tbl[r].tready;
            #1;
            chk($sformatf("row%0d ready", r), {60'd0, bus.req_ready}, {60'd0, tbl[r].exp_ready});
            if (tbl[r].exp_ready != 4'b0000) exp_cnt = exp_cnt + 32'd1;
            tick();
            check_out($sformatf("row%0d", r), tbl[r].exp_tvalid, tbl[r].exp_id, tbl[r].exp_dout);
        end

        // Backpressure: hold 0x10 for four cycles while req2 waits.
        set_pair(0, 64'h8, 64'h8);
        bus.req_valid   = 4'b0001;
        bus.rr_mode     = 1'b0;
        bus.dout_tready = 1'b1;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check_out("stall load", 1'b1, 2'd0, 64'h10);
        set_pair(2, 64'h20, 64'h3);
        bus.req_valid   = 4'b0100;
        bus.dout_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stall%0d ready", c), {60'd0, bus.req_ready}, 64'd0);
            tick();
            check_out($sformatf("stall%0d", c), 1'b1, 2'd0, 64'h10);
        end
        bus.dout_tready = 1'b1;
        #1;
        chk("release ready", {60'd0, bus.req_ready}, {60'd0, 4'b0100});
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check_out("release", 1'b1, 2'd2, 64'h23);

        // Carry out of the top bit is discarded, then an idle cycle drains.
        set_pair(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        bus.req_valid = 4'b0010;
        #1;
        chk("wrap ready", {60'd0, bus.req_ready}, {60'd0, 4'b0010});
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check_out("wrap", 1'b1, 2'd1, 64'd1);
        bus.req_valid = 4'b0000;
        tick();
        check_out("drain", 1'b0, 2'd0, 64'd0);

        // Asynchronous reset while full and stalled.
        for (int i = 0; i < 4; i++) set_pair(i, 64'(i), 64'd100);
        bus.req_valid   = 4'b0001;
        bus.rr_mode     = 1'b1;
        bus.dout_tready = 1'b0;
        tick();
        exp_cnt = exp_cnt + 32'd1;
        check_out("pre-reset", 1'b1, 2'd0, 64'd100);
        tick();
        check_out("pre-reset stall", 1'b1, 2'd0, 64'd100);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 32'd0;
        check_out("async reset", 1'b0, 2'd0, 64'd0);
        chk("async reset ready", {60'd0, bus.req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid   = 4'b1111;
        bus.dout_tready = 1'b1;
        #1;
        chk("post-reset ready", {60'd0, bus.req_ready}, {60'd0, 4'b0001});
        tick();
        exp_cnt = 32'd1;
        check_out("post-reset", 1'b1, 2'd0, 64'd100);

        // Counter wrap on the 4-bit instance: 15 grants, then one more.
        repeat (14) begin
            tick();
            exp_cnt = exp_cnt + 32'd1;
        end
        chk("cnt max", {32'd0, bus.grant_cnt}, {32'd0, exp_cnt});
        chk("cnt_n max", {60'd0, bus_n.grant_cnt}, {60'd0, 4'hF});
        tick();
        exp_cnt = exp_cnt + 32'd1;
        chk("cnt after", {32'd0, bus.grant_cnt}, {32'd0, exp_cnt});
        chk("cnt_n wrap", {60'd0, bus_n.grant_cnt}, 64'd0);

        bus.req_valid = 4'b0000;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
